// File: rtl/window3x3_gen.sv
// 3x3 sliding-window generator over a raster pixel stream.
// Two line buffers feed the upper window rows; a window is flagged once row>=2 and col>=2.
module window3x3_gen #(
    parameter int unsigned IMG_W = 8,
    parameter int unsigned IMG_H = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       Enable,
    input  logic [7:0] pix_in,
    input  logic       pix_valid,
    output logic [7:0] r1,
    output logic [7:0] r2,
    output logic [7:0] r3,
    output logic [7:0] r4,
    output logic [7:0] r5,
    output logic [7:0] r6,
    output logic [7:0] r7,
    output logic [7:0] r8,
    output logic [7:0] r9,
    output logic       win_valid,
    output logic       frame_done
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FILL   = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [8:0][7:0] win_q, win_d;
    logic            win_valid_q, win_valid_d;
    logic            frame_done_q, frame_done_d;

    // lb1 holds row y-1, lb2 holds row y-2; contents are never reset
    logic [7:0] lb1_q [IMG_W];
    logic [7:0] lb2_q [IMG_W];

    logic accept;
    logic col_last;
    logic row_last;
    logic in_window;

    always_comb begin
        accept    = Enable & pix_valid;
        col_last  = (col_q == CW'(IMG_W - 1));
        row_last  = (row_q == RW'(IMG_H - 1));
        in_window = (col_q >= CW'(2)) && (row_q >= RW'(2));
    end

    // Raster position counters; both return to 0 after the last pixel of a frame
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Window shifts left; the new right column comes from both line buffers and pix_in
    always_comb begin
        win_d = win_q;
        if (accept) begin
            win_d[0] = win_q[1];
            win_d[1] = win_q[2];
            win_d[2] = lb2_q[col_q];
            win_d[3] = win_q[4];
            win_d[4] = win_q[5];
            win_d[5] = lb1_q[col_q];
            win_d[6] = win_q[7];
            win_d[7] = win_q[8];
            win_d[8] = pix_in;
        end
    end

    // Frame FSM; DONE lasts exactly one cycle and drives frame_done
    always_comb begin
        state_d      = state_q;
        win_valid_d  = accept & in_window;
        frame_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_FILL;
            end
            ST_FILL: begin
                if (accept && row_last && col_last) begin
                    state_d = ST_DONE;
                end else if (accept && (row_q == RW'(2)) && (col_q == CW'(2))) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (accept && row_last && col_last) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        frame_done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            lb2_q[col_q] <= lb1_q[col_q];
            lb1_q[col_q] <= pix_in;
        end
    end

    assign r1         = win_q[0];
    assign r2         = win_q[1];
    assign r3         = win_q[2];
    assign r4         = win_q[3];
    assign r5         = win_q[4];
    assign r6         = win_q[5];
    assign r7         = win_q[6];
    assign r8         = win_q[7];
    assign r9         = win_q[8];
    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window3x3_gen.sv
// Directed bench for window3x3_gen: a 4x4 instance for streaming, gaps, stalls and reset,
// and a 3x3 instance for the single-window frame.
module tb_window3x3_gen;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       pv;
    logic [7:0] pin;
    logic [7:0] a1, a2, a3, a4, a5, a6, a7, a8, a9;
    logic       a_wv, a_fd;

    logic       pv_b;
    logic [7:0] pin_b;
    logic [7:0] b1, b2, b3, b4, b5, b6, b7, b8, b9;
    logic       b_wv, b_fd;

    int total;
    int bad;

    logic [71:0] exp_tab [4];

    window3x3_gen #(.IMG_W(4), .IMG_H(4)) u_dut_a (
        .clock(clk), .reset_n(rst_n), .Enable(en), .pix_in(pin), .pix_valid(pv),
        .r1(a1), .r2(a2), .r3(a3), .r4(a4), .r5(a5), .r6(a6), .r7(a7), .r8(a8), .r9(a9),
        .win_valid(a_wv), .frame_done(a_fd)
    );

    window3x3_gen #(.IMG_W(3), .IMG_H(3)) u_dut_b (
        .clock(clk), .reset_n(rst_n), .Enable(1'b1), .pix_in(pin_b), .pix_valid(pv_b),
        .r1(b1), .r2(b2), .r3(b3), .r4(b4), .r5(b5), .r6(b6), .r7(b7), .r8(b8), .r9(b9),
        .win_valid(b_wv), .frame_done(b_fd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [71:0] win_a();
        return {a1, a2, a3, a4, a5, a6, a7, a8, a9};
    endfunction

    function automatic logic [71:0] add_base(input logic [71:0] w, input logic [7:0] b);
        logic [71:0] r;
        for (int i = 0; i < 9; i++) r[i*8 +: 8] = w[i*8 +: 8] + b;
        return r;
    endfunction

    // Feed npix pixels base+0.. of a 4x4 frame, checking every cycle that follows
    task automatic frame4(input logic [7:0] base, input bit gap, input int stall_after,
                          input int npix);
        int  wi;
        bit  is_win;
        wi = 0;
        for (int p = 0; p < npix; p++) begin
            en  = 1'b1;
            pv  = 1'b1;
            pin = base + 8'(p);
            @(posedge clk); #1;
            pv = 1'b0;
            is_win = (p == 10) || (p == 11) || (p == 14) || (p == 15);
            check("wv", 72'(a_wv), 72'(is_win));
            check("fd", 72'(a_fd), 72'(p == 15));
            if (is_win) begin
                check("win", win_a(), add_base(exp_tab[wi], base));
                wi++;
            end
            if (gap) begin
                @(posedge clk); #1;
                check("gap_wv", 72'(a_wv), 72'(0));
                check("gap_fd", 72'(a_fd), 72'(0));
            end
            if (p == stall_after) begin
                en  = 1'b0;
                pv  = 1'b1;
                pin = 8'hEE;
                for (int s = 0; s < 5; s++) begin
                    @(posedge clk); #1;
                    check("stall_wv", 72'(a_wv), 72'(0));
                end
                en = 1'b1;
                pv = 1'b0;
            end
        end
    endtask

    initial begin
        logic [7:0]  seq [9];
        logic [71:0] exp_b;
        total = 0;
        bad   = 0;
        exp_tab[0] = {8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10};
        exp_tab[1] = {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11};
        exp_tab[2] = {8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10, 8'd12, 8'd13, 8'd14};
        exp_tab[3] = {8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15};
        seq = '{8'd191, 8'd187, 8'd194, 8'd185, 8'd205, 8'd200, 8'd195, 8'd190, 8'd186};
        exp_b = {8'd191, 8'd187, 8'd194, 8'd185, 8'd205, 8'd200, 8'd195, 8'd190, 8'd186};

        rst_n = 1'b0; en = 1'b1; pv = 1'b0; pin = 8'h00; pv_b = 1'b0; pin_b = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_win", win_a(), 72'(0));
        check("rst_wv", 72'(a_wv), 72'(0));
        check("rst_fd", 72'(a_fd), 72'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back frame, then a second frame straight after it
        frame4(8'd0, 1'b0, -1, 16);
        frame4(8'd100, 1'b0, -1, 16);
        // pix_valid low every other cycle
        frame4(8'd0, 1'b1, -1, 16);
        // Enable low for 5 cycles with pix_valid high after pixel 6
        frame4(8'd0, 1'b0, 6, 16);

        // Abort after pixel 9 with an asynchronous reset, then a full frame
        frame4(8'd0, 1'b0, -1, 10);
        rst_n = 1'b0;
        #2;
        check("arst_win", win_a(), 72'(0));
        check("arst_wv", 72'(a_wv), 72'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        frame4(8'd0, 1'b0, -1, 16);

        // 3x3 frame produces exactly one window
        for (int p = 0; p < 9; p++) begin
            pv_b  = 1'b1;
            pin_b = seq[p];
            @(posedge clk); #1;
            pv_b = 1'b0;
            check("b_wv", 72'(b_wv), 72'(p == 8));
            check("b_fd", 72'(b_fd), 72'(p == 8));
        end
        check("b_win", {b1, b2, b3, b4, b5, b6, b7, b8, b9}, exp_b);
        @(posedge clk); #1;
        check("b_wv_after", 72'(b_wv), 72'(0));
        check("b_fd_after", 72'(b_fd), 72'(0));
        check("b_win_hold", {b1, b2, b3, b4, b5, b6, b7, b8, b9}, exp_b);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/window3x3_gen.md
WINDOW3X3_GEN -- requirements
Module: window3x3_gen

Interface
REQ-001 SHALL have parameter IMG_W, default 8, meaning pixels per image row (legal range 3..1024).
REQ-002 SHALL have parameter IMG_H, default 8, meaning rows per frame (legal range 3..1024).
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port Enable, input, 1 bit: block enable; when low, all state is held.
REQ-006 SHALL have port pix_in, input, 8 bits: incoming pixel, raster order.
REQ-007 SHALL have port pix_valid, input, 1 bit: pix_in is accepted on a rising edge when pix_valid=1 and Enable=1.
REQ-008 SHALL have ports r1..r9, output, 8 bits each: 3x3 window. r1..r3 = top row, r4..r6 = middle row, r7..r9 = bottom row (current line); left to right within each row.
REQ-009 SHALL have port win_valid, output, 1 bit: r1..r9 hold a new complete window this cycle (one-cycle pulse).
REQ-010 SHALL have port frame_done, output, 1 bit: one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-011 SHALL keep two line buffers of IMG_W x 8 bits, addressed by column counter col, holding rows y-1 and y-2.
REQ-012 SHALL keep a 3x3 shift register. On each accepted pixel, columns shift left and the new right column is loaded as {linebuf2[col], linebuf1[col], pix_in}.
REQ-013 On the same edge, the line buffers SHALL update as linebuf2[col] <= linebuf1[col] and linebuf1[col] <= pix_in.
REQ-014 SHALL count col 0..IMG_W-1 and row 0..IMG_H-1. col wraps to 0 and row increments after col=IMG_W-1.
REQ-015 SHALL implement an FSM with states IDLE, FILL, STREAM and DONE.
- IDLE -> FILL on the first accepted pixel.
- FILL -> STREAM when the accepted pixel has row=2, col=2.
- STREAM -> DONE when the accepted pixel has row=IMG_H-1, col=IMG_W-1.
- DONE -> IDLE unconditionally on the next cycle.
REQ-016 SHALL pulse win_valid exactly one cycle after accepting a pixel with row>=2 and col>=2. Latency is 1 cycle; no border padding.
REQ-017 SHALL produce exactly (IMG_H-2)*(IMG_W-2) windows per frame.
REQ-018 Pixels with col<2 SHALL still shift and update the line buffers, but SHALL NOT raise win_valid. This prevents cross-row windows after wrap.
REQ-019 r1..r9 SHALL hold their value between windows and change only on accepted pixels.
REQ-020 frame_done SHALL be high in the DONE state only. It pulses in the same cycle as the final win_valid.
REQ-021 On frame completion, col and row SHALL return to 0. The next pixel starts a new frame, and old line-buffer contents never produce a window because the row<2 gating applies.
REQ-022 Gaps in pix_valid SHALL freeze all state, with no bubbles or duplicate windows. Enable=0 SHALL behave as a gap even when pix_valid=1.
REQ-023 All arithmetic SHALL be unsigned. Counter widths SHALL be clog2(IMG_W) and clog2(IMG_H).

Reset
REQ-024 reset_n=0 SHALL asynchronously clear:
- FSM to IDLE;
- col and row to 0;
- r1..r9 to 0;
- win_valid and frame_done to 0.
Line-buffer contents need not be cleared.
REQ-025 Reset asserted mid-frame SHALL abort the frame. The first accepted pixel after release SHALL be treated as row 0, col 0.

Verification
REQ-026 IMG_W=4, IMG_H=4, pixels 0..15 back-to-back -> windows:
- after pixel 10: r1..r9 = 0,1,2,4,5,6,8,9,10;
- after pixel 11: 1,2,3,5,6,7,9,10,11;
- after pixel 14: 4,5,6,8,9,10,12,13,14;
- after pixel 15: 5,6,7,9,10,11,13,14,15.
Exactly 4 win_valid pulses; frame_done coincides with the fourth.
REQ-027 Same frame, pix_valid low every other cycle -> identical 4 windows, each 1 cycle after its pixel; no extra pulses.
REQ-028 Enable=0 held for 5 cycles with pix_valid=1 mid-frame -> no state change. Resume yields the same windows as REQ-026.
REQ-029 reset_n pulsed low after pixel 9, then pixels 0..15 -> no window before the new pixel 10. Results equal REQ-026.
REQ-030 Two consecutive frames (second = pixels 100..115) -> second frame's first window = 100,101,102,104,105,106,108,109,110. No window contains first-frame values.
REQ-031 IMG_W=3, IMG_H=3, pixels 191,187,194,185,205,200,195,190,186 -> a single window equal to that sequence, with frame_done asserted.
